bank_wbuffer_mport: RTL and testbench
=====================================

Name: bank_wbuffer_mport

Overview:
Parametrised, multi-reader successor to the bank write buffer. The xbar-side write path stores each write into an entry selected by wbuffer id, using a byte strobe that merges into any data already held. Several bank-internal consumers (sram controller, BIU writeback path, ...) issue read requests, which are arbitrated round-robin. Read data returns through one registered ready/valid channel. Each entry carries a valid bit with a hit/miss indication, and an entry can be released as it is read.

Parameters:
DATA_WIDTH, 128, entry data width in bits; multiple of 8
ID_WIDTH, 5, entry id width; DEPTH = 2**ID_WIDTH
NUM_RD, 2, number of read requesters; >= 1
PORT_W, $clog2(NUM_RD) min 1, width of the return port index (derived)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-low
wbuf_wr_req_i  in  1  write strobe; always accepted
wbuf_wr_id_i  in  ID_WIDTH  target entry
wbuf_wdata_i  in  DATA_WIDTH  write data
wbuf_wstrb_i  in  DATA_WIDTH/8  byte enables
wbuf_rd_req_i  in  NUM_RD  per-requester read request; held until granted
wbuf_rd_id_i  in  NUM_RD*ID_WIDTH  per-requester entry id; requester r uses slice [r*ID_WIDTH +: ID_WIDTH]
wbuf_rd_release_i  in  NUM_RD  free the entry when this read is granted
wbuf_rd_gnt_o  out  NUM_RD  one-hot grant, combinational
wbuf_rtn_valid_o  out  1  return data valid
wbuf_rtn_ready_i  in  1  return consumer ready
wbuf_rtn_port_o  out  PORT_W  index of the granted requester
wbuf_rtn_miss_o  out  1  the entry was invalid at grant
wbuf_rtn_data_o  out  DATA_WIDTH  entry data; zero on a miss
wbuf_entry_valid_o  out  DEPTH  per-entry valid bits
wbuf_count_o  out  ID_WIDTH+1  number of valid entries

Behaviour:
- Reset (rst_i==0 at a clock edge): all valid bits 0; count 0; rtn_valid 0; rtn_port 0; rtn_miss 0; rtn_data 0; round-robin pointer 0. The data array is not reset.
- Write to an invalid entry:
  - Strobed bytes take wdata; unstrobed bytes become 0.
  - Entry becomes valid.
- Write to a valid entry: strobed bytes are overwritten and the other bytes keep their value (merge).
- Write with wstrb==0 still sets the entry valid (unwritten bytes follow the two rules above).
- Return register:
  - can_issue = !rtn_valid_o | wbuf_rtn_ready_i.
  - A grant is issued only when can_issue==1; otherwise gnt_o==0.
- Arbitration:
  - Round-robin among the asserted rd_req bits, starting search at the pointer.
  - On a grant to requester r, the pointer becomes (r+1) mod NUM_RD.
  - With NUM_RD==1 the arbiter reduces to gnt = req & can_issue.
- Grant cycle T. At edge T+1:
  - rtn_valid=1; rtn_port=r; rtn_miss = !valid[id]; rtn_data = miss ? 0 : array[id].
  - All values are sampled before any write in cycle T takes effect (read-before-write, no forwarding).
  - Latency is 1 cycle from grant to rtn_valid.
- Return handshake:
  - Return holds stable while rtn_valid & !rtn_ready.
  - Fire on rtn_valid & rtn_ready with no new grant: rtn_valid drops to 0 at the next edge.
  - Fire and a new grant in the same cycle: back-to-back, full throughput.
- Release:
  - When the grant includes release, the entry's valid bit clears at T+1.
  - Release of an invalid entry has no effect (miss still reported).
- Write and release to the same id in the same cycle:
  - Entry ends valid and is treated as freshly allocated: strobed bytes = wdata, others 0.
  - Count does not change.
- wbuf_count_o is updated by (+1 write to an invalid entry) (-1 effective release); both events in one cycle net to 0. The count saturates by construction at DEPTH.
- wbuf_entry_valid_o and wbuf_count_o are registered; they reflect state after the edge.
- Reset during a pending return: the return is dropped, rtn_valid is 0 next cycle, and no handshake completes.

Test Plan:
- Reset, then write id 3 with wdata=0xAA..AA and wstrb=all ones; requester 0 reads id 3 with rtn_ready=1 -> one cycle after grant: rtn_valid=1, port=0, miss=0, data=0xAA..AA; count=1, valid[3]=1.
- Byte merge: write id 5 data=0x11..11 all strobes, then write id 5 data=0x22..22 wstrb=0x000F -> read returns upper 12 bytes 0x11 and lower 4 bytes 0x22.
- Arbitration: NUM_RD=2, both requesters hold req for 4 cycles, rtn_ready=1 -> grants alternate 0,1,0,1; rtn_port follows 0,1,0,1 with 1-cycle lag.
- Backpressure: rtn_ready=0 for 3 cycles with req asserted -> gnt=0 for those cycles; rtn_data/port held stable; next grant occurs in the cycle rtn_ready rises.
- Release and miss: read id 7 with release=1 after a write -> miss=0 and count decrements by 1; a second read of id 7 -> miss=1, data=0.
- Same-cycle conflicts: write id 2 while requester 1 reads id 2 (old content 0x33..33) -> returned data is 0x33..33. Then release+write id 2 in one cycle -> valid[2]=1 and count unchanged.

Source files
------------

// File: rtl/bank_wbuffer_mport.sv
// Multi-reader bank write buffer: strobed merge writes by id, round-robin
// arbitrated reads returned through one registered ready/valid channel.
module bank_wbuffer_mport #(
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 5,
  parameter int NUM_RD     = 2,
  parameter int PORT_W     = (NUM_RD > 1) ? $clog2(NUM_RD) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wbuf_wr_req_i,
  input  logic [ID_WIDTH-1:0]          wbuf_wr_id_i,
  input  logic [DATA_WIDTH-1:0]        wbuf_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]      wbuf_wstrb_i,
  input  logic [NUM_RD-1:0]            wbuf_rd_req_i,
  input  logic [NUM_RD*ID_WIDTH-1:0]   wbuf_rd_id_i,
  input  logic [NUM_RD-1:0]            wbuf_rd_release_i,
  output logic [NUM_RD-1:0]            wbuf_rd_gnt_o,
  output logic                         wbuf_rtn_valid_o,
  input  logic                         wbuf_rtn_ready_i,
  output logic [PORT_W-1:0]            wbuf_rtn_port_o,
  output logic                         wbuf_rtn_miss_o,
  output logic [DATA_WIDTH-1:0]        wbuf_rtn_data_o,
  output logic [2**ID_WIDTH-1:0]       wbuf_entry_valid_o,
  output logic [ID_WIDTH:0]            wbuf_count_o
);

  localparam int DEPTH = 2**ID_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;
  localparam int CW    = ID_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [CW-1:0]         count_q;
  logic [PORT_W-1:0]     rr_ptr;

  logic                  can_issue;
  logic                  gnt_any;
  logic [PORT_W-1:0]     gnt_idx;
  logic [NUM_RD-1:0]     gnt;
  logic [ID_WIDTH-1:0]   rd_id_sel;
  logic                  rel_sel;
  logic                  rel_eff;
  logic                  same_id;
  logic                  wr_fresh;
  logic                  cnt_inc;
  logic                  cnt_dec;
  logic [DATA_WIDTH-1:0] wr_merged;

  assign can_issue = !wbuf_rtn_valid_o | wbuf_rtn_ready_i;

  always_comb begin
    int unsigned       idx;
    logic [PORT_W-1:0] idx_p;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    idx_p   = '0;
    if (can_issue) begin
      for (int unsigned i = 0; i < NUM_RD; i++) begin
        idx   = (int'(rr_ptr) + i) % NUM_RD;
        idx_p = PORT_W'(idx);
        if (!gnt_any && wbuf_rd_req_i[idx_p]) begin
          gnt[idx_p] = 1'b1;
          gnt_any    = 1'b1;
          gnt_idx    = idx_p;
        end
      end
    end
  end

  assign wbuf_rd_gnt_o = gnt;
  assign rd_id_sel     = wbuf_rd_id_i[gnt_idx*ID_WIDTH +: ID_WIDTH];
  assign rel_sel       = wbuf_rd_release_i[gnt_idx];
  assign rel_eff       = gnt_any & rel_sel & valid_q[rd_id_sel];
  assign same_id       = wbuf_wr_req_i & (wbuf_wr_id_i == rd_id_sel);

  // A write landing on an entry released in the same cycle starts from zero,
  // and the release does not count as a free since the entry stays occupied.
  assign wr_fresh = !valid_q[wbuf_wr_id_i] | (gnt_any & rel_sel & same_id);
  assign cnt_inc  = wbuf_wr_req_i & !valid_q[wbuf_wr_id_i];
  assign cnt_dec  = rel_eff & !same_id;

  always_comb begin
    wr_merged = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (wbuf_wstrb_i[b])
        wr_merged[b*8 +: 8] = wbuf_wdata_i[b*8 +: 8];
      else if (!wr_fresh)
        wr_merged[b*8 +: 8] = mem[wbuf_wr_id_i][b*8 +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (wbuf_wr_req_i)
      mem[wbuf_wr_id_i] <= wr_merged;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q          <= '0;
      count_q          <= '0;
      rr_ptr           <= '0;
      wbuf_rtn_valid_o <= 1'b0;
      wbuf_rtn_port_o  <= '0;
      wbuf_rtn_miss_o  <= 1'b0;
      wbuf_rtn_data_o  <= '0;
    end else begin
      if (rel_eff)
        valid_q[rd_id_sel] <= 1'b0;
      if (wbuf_wr_req_i)
        valid_q[wbuf_wr_id_i] <= 1'b1;
      count_q <= count_q + CW'(cnt_inc) - CW'(cnt_dec);
      if (gnt_any) begin
        wbuf_rtn_valid_o <= 1'b1;
        wbuf_rtn_port_o  <= gnt_idx;
        wbuf_rtn_miss_o  <= !valid_q[rd_id_sel];
        wbuf_rtn_data_o  <= valid_q[rd_id_sel] ? mem[rd_id_sel] : '0;
        if (int'(gnt_idx) == NUM_RD - 1)
          rr_ptr <= '0;
        else
          rr_ptr <= gnt_idx + 1'b1;
      end else if (wbuf_rtn_ready_i) begin
        wbuf_rtn_valid_o <= 1'b0;
      end
    end
  end

  assign wbuf_entry_valid_o = valid_q;
  assign wbuf_count_o       = count_q;

endmodule

// File: tb/tb_bank_wbuffer_mport.sv
// Directed self-checking bench for bank_wbuffer_mport (128-bit data, 32 entries, 2 readers).
module tb_bank_wbuffer_mport;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         wr_req = 1'b0;
  logic [4:0]   wr_id = '0;
  logic [127:0] wdata = '0;
  logic [15:0]  wstrb = '0;
  logic [1:0]   rd_req = '0;
  logic [9:0]   rd_id = '0;
  logic [1:0]   rd_rel = '0;
  logic [1:0]   gnt;
  logic         rtn_valid;
  logic         rtn_ready = 1'b1;
  logic [0:0]   rtn_port;
  logic         rtn_miss;
  logic [127:0] rtn_data;
  logic [31:0]  entry_valid;
  logic [5:0]   count;

  int passed = 0;
  int total  = 0;

  localparam logic [127:0] DAA = {16{8'hAA}};
  localparam logic [127:0] DMG = {{12{8'h11}}, {4{8'h22}}};
  localparam logic [127:0] D77 = {16{8'h77}};
  localparam logic [127:0] D33 = {16{8'h33}};
  localparam logic [127:0] D44 = {16{8'h44}};

  bank_wbuffer_mport #(.DATA_WIDTH(128), .ID_WIDTH(5), .NUM_RD(2)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .wbuf_wr_req_i      (wr_req),
    .wbuf_wr_id_i       (wr_id),
    .wbuf_wdata_i       (wdata),
    .wbuf_wstrb_i       (wstrb),
    .wbuf_rd_req_i      (rd_req),
    .wbuf_rd_id_i       (rd_id),
    .wbuf_rd_release_i  (rd_rel),
    .wbuf_rd_gnt_o      (gnt),
    .wbuf_rtn_valid_o   (rtn_valid),
    .wbuf_rtn_ready_i   (rtn_ready),
    .wbuf_rtn_port_o    (rtn_port),
    .wbuf_rtn_miss_o    (rtn_miss),
    .wbuf_rtn_data_o    (rtn_data),
    .wbuf_entry_valid_o (entry_valid),
    .wbuf_count_o       (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] id, input logic [127:0] d, input logic [15:0] s);
    wr_req = 1'b1; wr_id = id; wdata = d; wstrb = s;
    step();
    wr_req = 1'b0;
  endtask

  task automatic idle();
    rd_req = '0; rd_rel = '0; wr_req = 1'b0;
  endtask

  logic [1:0] exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    // reset
    step(); step();
    check("rst_valid", 128'(rtn_valid), 128'(0));
    check("rst_count", 128'(count), 128'(0));
    check("rst_entries", 128'(entry_valid), 128'(0));
    check("rst_port", 128'(rtn_port), 128'(0));
    check("rst_miss", 128'(rtn_miss), 128'(0));
    check("rst_data", rtn_data, 128'(0));
    rst = 1'b1;

    // basic write and read
    write(5'd3, DAA, 16'hFFFF);
    check("wr3_count", 128'(count), 128'(1));
    check("wr3_valid", 128'(entry_valid[3]), 128'(1));
    rd_req = 2'b01; rd_id = {5'd0, 5'd3};
    #1 check("rd3_gnt", 128'(gnt), 128'(2'b01));
    step();
    check("rd3_rvalid", 128'(rtn_valid), 128'(1));
    check("rd3_port", 128'(rtn_port), 128'(0));
    check("rd3_miss", 128'(rtn_miss), 128'(0));
    check("rd3_data", rtn_data, DAA);
    idle(); step();
    check("drain_rvalid", 128'(rtn_valid), 128'(0));

    // byte merge, read by requester 1 (pointer currently 1)
    write(5'd5, {16{8'h11}}, 16'hFFFF);
    write(5'd5, {16{8'h22}}, 16'h000F);
    rd_req = 2'b10; rd_id = {5'd5, 5'd0};
    #1 check("merge_gnt", 128'(gnt), 128'(2'b10));
    step();
    check("merge_data", rtn_data, DMG);
    check("merge_port", 128'(rtn_port), 128'(1));
    idle(); step();

    // round-robin with both requesting
    rd_req = 2'b11; rd_id = {5'd5, 5'd3};
    for (int k = 0; k < 4; k++) begin
      #1 check("arb_gnt", 128'(gnt), 128'(exp_gnt[k]));
      step();
      check("arb_port", 128'(rtn_port), 128'(k % 2));
      check("arb_data", rtn_data, (k % 2 == 0) ? DAA : DMG);
    end

    // backpressure: last return (port 1) must hold
    rd_req = 2'b01; rd_id = {5'd0, 5'd3}; rtn_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check("bp_gnt", 128'(gnt), 128'(0));
      step();
      check("bp_port", 128'(rtn_port), 128'(1));
      check("bp_data", rtn_data, DMG);
      check("bp_valid", 128'(rtn_valid), 128'(1));
    end
    rtn_ready = 1'b1;
    #1 check("bp_release_gnt", 128'(gnt), 128'(2'b01));
    step();
    check("bp_after_port", 128'(rtn_port), 128'(0));
    check("bp_after_data", rtn_data, DAA);
    idle(); step();

    // release and miss
    write(5'd7, D77, 16'hFFFF);
    check("wr7_count", 128'(count), 128'(3));
    rd_req = 2'b10; rd_id = {5'd7, 5'd0}; rd_rel = 2'b10;
    step();
    check("rel_miss", 128'(rtn_miss), 128'(0));
    check("rel_data", rtn_data, D77);
    check("rel_count", 128'(count), 128'(2));
    check("rel_valid7", 128'(entry_valid[7]), 128'(0));
    idle(); step();
    rd_req = 2'b01; rd_id = {5'd0, 5'd7};
    step();
    check("miss_flag", 128'(rtn_miss), 128'(1));
    check("miss_data", rtn_data, 128'(0));
    check("miss_count", 128'(count), 128'(2));
    idle(); step();

    // same-cycle write and read: read sees old content
    write(5'd2, D33, 16'hFFFF);
    rd_req = 2'b10; rd_id = {5'd2, 5'd0};
    wr_req = 1'b1; wr_id = 5'd2; wdata = D44; wstrb = 16'hFFFF;
    step();
    check("rbw_data", rtn_data, D33);
    check("rbw_count", 128'(count), 128'(3));
    // release + write same id: stays valid, freshly allocated
    rd_req = 2'b01; rd_id = {5'd0, 5'd2}; rd_rel = 2'b01;
    wr_req = 1'b1; wr_id = 5'd2; wdata = {16{8'h55}}; wstrb = 16'h0001;
    step();
    check("relwr_data", rtn_data, D44);
    check("relwr_valid2", 128'(entry_valid[2]), 128'(1));
    check("relwr_count", 128'(count), 128'(3));
    idle();
    rd_req = 2'b10; rd_id = {5'd2, 5'd0};
    step();
    check("fresh_data", rtn_data, 128'h55);
    check("fresh_miss", 128'(rtn_miss), 128'(0));

    // reset with a pending return
    idle(); rtn_ready = 1'b0; rst = 1'b0;
    step();
    check("rst_pend_valid", 128'(rtn_valid), 128'(0));
    check("rst_pend_count", 128'(count), 128'(0));
    rst = 1'b1; rtn_ready = 1'b1;

    // zero-strobe write still allocates
    write(5'd9, {16{8'hFF}}, 16'h0000);
    check("zs_count", 128'(count), 128'(1));
    rd_req = 2'b01; rd_id = {5'd0, 5'd9};
    step();
    check("zs_miss", 128'(rtn_miss), 128'(0));
    check("zs_data", rtn_data, 128'(0));
    idle(); step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
